block_scheduler: RTL and testbench
==================================

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 Parameter BASE_PERIOD, default 8: ticks per step at level 0 (legal range 8..255).
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value (nonzero).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle timebase pulse from the divider.
REQ-006 start  input  1  one-cycle pulse; leaves IDLE.
REQ-007 btn_left, btn_right  input  1 each  debounced one-cycle move pulses.
REQ-008 pause  input  1  level; 1 = hold game.
REQ-009 gameover  input  1  collision flag from the judge block.
REQ-010 blocks  output  64  grid: [63:56] top row, [7:0] bottom (player) row.
REQ-011 aim  output  8  one-hot player position on bottom row.
REQ-012 step  output  1  one-cycle pulse in the cycle blocks changes.
REQ-013 score  output  16  steps survived, saturating.
REQ-014 level  output  3  speed level, saturating at 7.
REQ-015 state  output  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.

Function
REQ-016 FSM: IDLE->RUN on start; RUN->PAUSE when pause=1; PAUSE->RUN when pause=0; RUN or PAUSE->OVER when gameover=1; OVER exits only via rst.
REQ-017 gameover has priority over pause and start; OVER is entered the cycle after gameover=1.
REQ-018 Tick counter (8 bit) increments only on tick in RUN; when it equals period-1 on a tick: counter <= 0 and a step occurs.
REQ-019 period = BASE_PERIOD - level, evaluated at the tick; the counter is not cleared on a level change.
REQ-020 Step: blocks <= {new_row, blocks[63:8]}; step=1 for exactly the cycle after the completing tick (same cycle blocks updates).
REQ-021 LFSR: 16-bit Galois, right shift, mask 16'hB400 applied when the shifted-out bit is 1; advances only on steps.
REQ-022 new_row = 8'h00 on odd steps (step parity bit = 1); on even steps = next LFSR[7:0], substituted with 8'hFE if it equals 8'hFF.
REQ-023 Step parity bit resets to 0 and toggles each step.
REQ-024 score increments by 1 per step, saturating at 16'hFFFF.
REQ-025 level = min(7, score[15:5]), i.e. +1 every 32 steps.
REQ-026 Moves only in RUN: btn_left alone -> aim <= aim<<1 unless aim[7]=1; btn_right alone -> aim <= aim>>1 unless aim[0]=1; both together -> no move.
REQ-027 A move and a step in the same cycle are both applied.
REQ-028 If gameover=1 coincides with a completing tick, no step occurs: blocks, score and LFSR are unchanged.
REQ-029 PAUSE and OVER freeze blocks, aim, score, level, LFSR and the tick counter; ticks and buttons are ignored.
REQ-030 In IDLE: blocks=0, ticks and buttons are ignored.
REQ-031 aim stays one-hot at all times.

Reset
REQ-032 On rst: state=IDLE, blocks=0, aim=8'h10, score=0, level=0, step=0, tick counter=0, parity=0, LFSR=LFSR_SEED.
REQ-033 rst overrides all inputs in the same cycle, including mid-step and in OVER.

Verification
REQ-034 Assert rst for 1 clk -> blocks=0, aim=8'h10, score=0, level=0, state=0, step=0.
REQ-035 start, then 8 tick pulses -> no step after ticks 1-7; step=1 one cycle after tick 8 with blocks[63:56]=8'h70 (LFSR 16'hE270), score=1; next step gives blocks[63:56]=8'h00.
REQ-036 aim=8'h80 + btn_left -> aim stays 8'h80; btn_right -> 8'h40; both together -> unchanged; btn_left in PAUSE -> unchanged.
REQ-037 pause=1 after 3 ticks, then 10 ticks, then pause=0 -> no step while paused; the next step occurs after 5 more ticks.
REQ-038 gameover=1 in the same cycle as a completing tick -> state=OVER, no step, blocks and score unchanged; further ticks have no effect; rst -> IDLE.
REQ-039 32 steps -> level=1, period becomes 7 ticks; force score 16'hFFFF, then step -> score stays 16'hFFFF and level=7.

Source files
------------

// File: rtl/block_scheduler.sv
// Falling-blocks game scheduler: run/pause/over FSM, tick-driven scroll of an
// 8x8 block grid fed by a Galois LFSR, player aim, score and speed level.
module block_scheduler #(
  parameter int          BASE_PERIOD = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        pause,
  input  logic        gameover,
  output logic [63:0] blocks,
  output logic [7:0]  aim,
  output logic        step,
  output logic [15:0] score,
  output logic [2:0]  level,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [7:0] BASE = BASE_PERIOD[7:0];

  state_t      r_state;
  state_t      w_state_next;
  logic        w_active;
  logic [7:0]  r_tick_cnt;
  logic [15:0] r_lfsr;
  logic        r_parity;
  logic [63:0] r_blocks;
  logic [7:0]  r_aim;
  logic [15:0] r_score;
  logic        r_step;
  logic [2:0]  w_level;
  logic [7:0]  w_period;
  logic        w_tick_done;
  logic [15:0] w_lfsr_next;
  logic [7:0]  w_new_row;
  logic        w_move_left;
  logic        w_move_right;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // gameover wins over pause and start; OVER is left only through rst
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !gameover) w_state_next = S_RUN;
      S_RUN: begin
        if (gameover)   w_state_next = S_OVER;
        else if (pause) w_state_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (gameover)    w_state_next = S_OVER;
        else if (!pause) w_state_next = S_RUN;
      end
      default: w_state_next = S_OVER;
    endcase
  end

  always_comb begin
    w_active = (r_state == S_RUN) && !gameover;
    state    = r_state;
  end

  always_comb begin
    w_level     = (r_score[15:5] > 11'd7) ? 3'd7 : r_score[7:5];
    w_period    = BASE - {5'd0, w_level};
    w_tick_done = w_active && tick && (r_tick_cnt == (w_period - 8'd1));
    w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    if (r_parity)
      w_new_row = 8'h00;
    else if (w_lfsr_next[7:0] == 8'hFF)
      w_new_row = 8'hFE;  // a full row would be unsurvivable
    else
      w_new_row = w_lfsr_next[7:0];
    w_move_left  = w_active && btn_left && !btn_right && !r_aim[7];
    w_move_right = w_active && btn_right && !btn_left && !r_aim[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= 8'd0;
      r_lfsr     <= LFSR_SEED;
      r_parity   <= 1'b0;
      r_blocks   <= 64'd0;
      r_score    <= 16'd0;
      r_step     <= 1'b0;
    end else begin
      r_step <= w_tick_done;
      if (w_active && tick) begin
        r_tick_cnt <= w_tick_done ? 8'd0 : r_tick_cnt + 8'd1;
      end
      if (w_tick_done) begin
        r_blocks <= {w_new_row, r_blocks[63:8]};
        r_lfsr   <= w_lfsr_next;
        r_parity <= ~r_parity;
        if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aim <= 8'h10;
    end else if (w_move_left) begin
      r_aim <= {r_aim[6:0], 1'b0};
    end else if (w_move_right) begin
      r_aim <= {1'b0, r_aim[7:1]};
    end
  end

  assign blocks = r_blocks;
  assign aim    = r_aim;
  assign step   = r_step;
  assign score  = r_score;
  assign level  = w_level;

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: reset, scrolling, aim moves, pause,
// gameover coincidence, level-up and score saturation.
module tb_block_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        pause = 1'b0;
  logic        gameover = 1'b0;
  logic [63:0] blocks;
  logic [7:0]  aim;
  logic        step;
  logic [15:0] score;
  logic [2:0]  level;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  block_scheduler #(.BASE_PERIOD(8), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .pause(pause),
    .gameover(gameover), .blocks(blocks), .aim(aim), .step(step),
    .score(score), .level(level), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic pulse_btn(input logic l, input logic r);
    btn_left = l; btn_right = r; cyc(); btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    cyc();
    do_reset();
    check("rst_blocks", blocks, 64'd0);
    check("rst_aim", {56'd0, aim}, 64'h10);
    check("rst_score", {48'd0, score}, 64'd0);
    check("rst_level", {61'd0, level}, 64'd0);
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_step", {63'd0, step}, 64'd0);

    pulse_tick();
    pulse_btn(1'b1, 1'b0);
    check("idle_ignores_tick", {48'd0, score}, 64'd0);
    check("idle_ignores_btn", {56'd0, aim}, 64'h10);

    start = 1'b1; cyc(); start = 1'b0;
    check("start_run", {62'd0, state}, 64'd1);
    for (int i = 1; i <= 7; i++) begin
      pulse_tick();
      check($sformatf("no_step_tick%0d", i), {63'd0, step}, 64'd0);
    end
    pulse_tick();
    check("step1_pulse", {63'd0, step}, 64'd1);
    check("step1_blocks", blocks, 64'h7000_0000_0000_0000);
    check("step1_score", {48'd0, score}, 64'd1);
    cyc();
    check("step_one_cycle", {63'd0, step}, 64'd0);
    for (int i = 1; i <= 8; i++) pulse_tick();
    check("step2_blocks", blocks, 64'h0070_0000_0000_0000);
    check("step2_score", {48'd0, score}, 64'd2);

    pulse_btn(1'b1, 1'b0);
    pulse_btn(1'b1, 1'b0);
    pulse_btn(1'b1, 1'b0);
    check("aim_left3", {56'd0, aim}, 64'h80);
    pulse_btn(1'b1, 1'b0);
    check("aim_left_edge", {56'd0, aim}, 64'h80);
    pulse_btn(1'b0, 1'b1);
    check("aim_right", {56'd0, aim}, 64'h40);
    pulse_btn(1'b1, 1'b1);
    check("aim_both", {56'd0, aim}, 64'h40);
    pause = 1'b1; cyc();
    check("pause_state", {62'd0, state}, 64'd2);
    pulse_btn(1'b1, 1'b0);
    check("aim_paused", {56'd0, aim}, 64'h40);
    pause = 1'b0; cyc();
    check("resume_state", {62'd0, state}, 64'd1);

    for (int i = 1; i <= 3; i++) pulse_tick();
    pause = 1'b1; cyc();
    for (int i = 1; i <= 10; i++) begin
      pulse_tick();
      check($sformatf("paused_no_step%0d", i), {63'd0, step}, 64'd0);
    end
    check("paused_score", {48'd0, score}, 64'd2);
    pause = 1'b0; cyc();
    for (int i = 1; i <= 4; i++) begin
      pulse_tick();
      check($sformatf("resume_no_step%0d", i), {63'd0, step}, 64'd0);
    end
    pulse_tick();
    check("resume_step", {63'd0, step}, 64'd1);
    check("step3_score", {48'd0, score}, 64'd3);
    check("step3_blocks", blocks, 64'h9C00_7000_0000_0000);

    for (int i = 1; i <= 7; i++) pulse_tick();
    gameover = 1'b1; tick = 1'b1; cyc(); gameover = 1'b0; tick = 1'b0;
    check("over_state", {62'd0, state}, 64'd3);
    check("over_no_step", {63'd0, step}, 64'd0);
    check("over_score", {48'd0, score}, 64'd3);
    check("over_blocks", blocks, 64'h9C00_7000_0000_0000);
    for (int i = 1; i <= 8; i++) pulse_tick();
    start = 1'b1; cyc(); start = 1'b0;
    check("over_frozen_state", {62'd0, state}, 64'd3);
    check("over_frozen_score", {48'd0, score}, 64'd3);
    check("over_frozen_blocks", blocks, 64'h9C00_7000_0000_0000);
    do_reset();
    check("over_rst_state", {62'd0, state}, 64'd0);
    check("over_rst_blocks", blocks, 64'd0);
    check("over_rst_aim", {56'd0, aim}, 64'h10);

    start = 1'b1; cyc(); start = 1'b0;
    tick = 1'b1;
    repeat (256) cyc();
    tick = 1'b0;
    check("lvl_score32", {48'd0, score}, 64'd32);
    check("lvl_level1", {61'd0, level}, 64'd1);
    for (int i = 1; i <= 6; i++) pulse_tick();
    check("lvl1_no_step6", {48'd0, score}, 64'd32);
    pulse_tick();
    check("lvl1_step7", {63'd0, step}, 64'd1);
    check("lvl1_score33", {48'd0, score}, 64'd33);

    force dut.r_score = 16'hFFFF;
    cyc();
    release dut.r_score;
    cyc();
    check("sat_level7", {61'd0, level}, 64'd7);
    pulse_tick();
    check("sat_step", {63'd0, step}, 64'd1);
    check("sat_score", {48'd0, score}, 64'hFFFF);
    check("sat_level", {61'd0, level}, 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
